// File: rtl/sr_mathunit_arbiter.sv
// sr_mathunit_arbiter: round-robin front end that lets several requesters
// share one multi-cycle math unit with a start/busy interface. One
// transaction is in flight at a time. Operands are latched at grant time and
// the result (or a start-timeout error) is returned to the granted requester.
module sr_mathunit_arbiter #(
  parameter int NREQ      = 2,
  parameter int DW        = 32,
  parameter int START_TMO = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid_i,
  output logic [NREQ-1:0]    req_ready_o,
  input  logic [NREQ*DW-1:0] req_a_i,
  input  logic [NREQ*DW-1:0] req_b_i,
  output logic [NREQ-1:0]    rsp_valid_o,
  input  logic [NREQ-1:0]    rsp_ready_i,
  output logic [DW-1:0]      rsp_data_o,
  output logic               rsp_err_o,
  output logic               mu_start_o,
  output logic [DW-1:0]      mu_a_o,
  output logic [DW-1:0]      mu_b_o,
  input  logic               mu_busy_i,
  input  logic [DW-1:0]      mu_result_i
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // One extra bit so the counter cannot wrap before it reaches START_TMO-1.
  localparam int CW = $clog2(START_TMO) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_RUN,
    S_RESP
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   last_grant_q, last_grant_d;
  logic [IW-1:0]   gid_q, gid_d;
  logic [DW-1:0]   mu_a_q, mu_a_d;
  logic [DW-1:0]   mu_b_q, mu_b_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [IW-1:0]   grant;
  logic            grant_vld;
  logic [IW-1:0]   idx;

  // Round-robin pick: first valid requester after the last one served.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    idx       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(last_grant_q) + k) % NREQ);
      if (!grant_vld && req_valid_i[idx]) begin
        grant     = idx;
        grant_vld = 1'b1;
      end
    end
  end

  // Next-state and handshake outputs for the single in-flight transaction.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gid_d        = gid_q;
    mu_a_d       = mu_a_q;
    mu_b_d       = mu_b_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    cnt_d        = cnt_q;
    req_ready_o  = '0;
    rsp_valid_o  = '0;
    mu_start_o   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A busy unit (e.g. still draining another master) blocks all grants.
        if (!mu_busy_i && grant_vld) begin
          req_ready_o[grant] = 1'b1;
          mu_a_d             = req_a_i[grant*DW +: DW];
          mu_b_d             = req_b_i[grant*DW +: DW];
          gid_d              = grant;
          state_d            = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mu_start_o = 1'b1;
        cnt_d      = '0;
        state_d    = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (mu_busy_i) begin
          state_d = S_RUN;
        end else if (cnt_q == CW'(START_TMO - 1)) begin
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
          state_d    = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (!mu_busy_i) begin
          rsp_data_d = mu_result_i;
          rsp_err_d  = 1'b0;
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid_o[gid_q] = 1'b1;
        if (rsp_ready_i[gid_q]) begin
          last_grant_d = gid_q;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset makes requester 0 win first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= IW'(NREQ - 1);
      gid_q        <= '0;
      mu_a_q       <= '0;
      mu_b_q       <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gid_q        <= gid_d;
      mu_a_q       <= mu_a_d;
      mu_b_q       <= mu_b_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign mu_a_o     = mu_a_q;
  assign mu_b_o     = mu_b_q;
  assign rsp_data_o = rsp_data_q;
  assign rsp_err_o  = rsp_err_q;

endmodule
